// File: rtl/alu_op_issue.sv
// alu_op_issue: ID/EX stage register for the bit-sliced ALU control interface.
// Decodes the incoming MIPS word into function select, operand-invert and
// carry-in controls. It registers these controls together with the immediate
// and the register specifiers, handles stall and flush, and keeps a wrapping
// count of legal issues for debug.
module alu_op_issue #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [31:0]      id_instr,
   input  logic             stall,
   input  logic             flush,
   output logic             ex_valid,
   output logic [5:0]       ex_sel,
   output logic             ex_inv,
   output logic             ex_cin,
   output logic             ex_use_imm,
   output logic [31:0]      ex_imm,
   output logic [4:0]       ex_rs,
   output logic [4:0]       ex_rt,
   output logic [4:0]       ex_rd,
   output logic             ex_reg_write,
   output logic             ex_illegal,
   output logic [CNT_W-1:0] issue_count
);

   localparam logic [5:0] SEL_ADD = 6'd32;
   localparam logic [5:0] SEL_SUB = 6'd34;
   localparam logic [5:0] SEL_AND = 6'd36;
   localparam logic [5:0] SEL_OR  = 6'd37;
   localparam logic [5:0] SEL_SLT = 6'd42;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;

   typedef struct packed {
      logic        valid;
      logic [5:0]  sel;
      logic        inv;
      logic        cin;
      logic        useImm;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        regWrite;
      logic        illegal;
   } exCtrl_t;

   // An empty EX slot: nothing valid, nothing written, select parked on add.
   localparam exCtrl_t BUBBLE = '{
      valid: 1'b0, sel: SEL_ADD, inv: 1'b0, cin: 1'b0, useImm: 1'b0,
      imm: 32'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0, regWrite: 1'b0, illegal: 1'b0
   };

   logic [5:0]  w_op;
   logic [5:0]  w_funct;
   logic [31:0] w_immSext;
   logic [31:0] w_immZext;
   logic        w_legal;
   exCtrl_t     w_dec;
   exCtrl_t     w_next;
   exCtrl_t     r_ex;
   logic [CNT_W-1:0] r_count;

   assign w_op      = id_instr[31:26];
   assign w_funct   = id_instr[5:0];
   assign w_immSext = {{16{id_instr[15]}}, id_instr[15:0]};
   assign w_immZext = {16'd0, id_instr[15:0]};

   // Decode the instruction word; anything not recognised falls through as illegal.
   always_comb begin
      w_legal      = 1'b0;
      w_dec        = BUBBLE;
      w_dec.rs     = id_instr[25:21];
      w_dec.rt     = id_instr[20:16];
      if (id_instr == 32'd0) begin
         w_legal = 1'b1;
      end else begin
         case (w_op)
            OP_RTYPE: begin
               if (w_funct == SEL_ADD || w_funct == SEL_SUB || w_funct == SEL_AND ||
                   w_funct == SEL_OR  || w_funct == SEL_SLT) begin
                  w_legal        = 1'b1;
                  w_dec.sel      = w_funct;
                  w_dec.regWrite = 1'b1;
                  w_dec.rd       = id_instr[15:11];
               end
            end
            OP_ADDI, OP_SLTI: begin
               w_legal        = 1'b1;
               w_dec.sel      = (w_op == OP_ADDI) ? SEL_ADD : SEL_SLT;
               w_dec.imm      = w_immSext;
               w_dec.useImm   = 1'b1;
               w_dec.regWrite = 1'b1;
               w_dec.rd       = id_instr[20:16];
            end
            OP_ANDI, OP_ORI: begin
               w_legal        = 1'b1;
               w_dec.sel      = (w_op == OP_ANDI) ? SEL_AND : SEL_OR;
               w_dec.imm      = w_immZext;
               w_dec.useImm   = 1'b1;
               w_dec.regWrite = 1'b1;
               w_dec.rd       = id_instr[20:16];
            end
            OP_BEQ: begin
               w_legal   = 1'b1;
               w_dec.sel = SEL_SUB;
               w_dec.imm = w_immSext;
            end
            default: begin
               w_legal = 1'b0;
            end
         endcase
      end
      w_dec.valid   = w_legal;
      w_dec.illegal = ~w_legal;
      w_dec.inv     = w_legal && (w_dec.sel == SEL_SUB || w_dec.sel == SEL_SLT);
      w_dec.cin     = w_dec.inv;
   end

   // Flush and an empty ID slot both turn into a bubble; otherwise take the decode.
   always_comb begin
      w_next = w_dec;
      if (flush || !id_valid) begin
         w_next = BUBBLE;
      end
   end

   // EX control register: flush beats stall, stall freezes everything including the illegal flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex <= BUBBLE;
      end else if (flush || !stall) begin
         r_ex <= w_next;
      end
   end

   // Issue counter advances only on an unstalled, unflushed load of a legal word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (!flush && !stall && id_valid && w_legal) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign ex_valid     = r_ex.valid;
   assign ex_sel       = r_ex.sel;
   assign ex_inv       = r_ex.inv;
   assign ex_cin       = r_ex.cin;
   assign ex_use_imm   = r_ex.useImm;
   assign ex_imm       = r_ex.imm;
   assign ex_rs        = r_ex.rs;
   assign ex_rt        = r_ex.rt;
   assign ex_rd        = r_ex.rd;
   assign ex_reg_write = r_ex.regWrite;
   assign ex_illegal   = r_ex.illegal;
   assign issue_count  = r_count;

endmodule
